// File: rtl/scad_pkg.sv
// Shared definitions for the step-count adder / count-down loop engine.
package scad_pkg;

    // ALU function codes
    localparam logic [2:0] SCAD_A_PLUS_A          = 3'd0;
    localparam logic [2:0] SCAD_A_OR_B            = 3'd1;
    localparam logic [2:0] SCAD_A_MINUS_B_MINUS_1 = 3'd2;
    localparam logic [2:0] SCAD_A_MINUS_B         = 3'd3;
    localparam logic [2:0] SCAD_A_PLUS_B          = 3'd4;
    localparam logic [2:0] SCAD_A_AND_B           = 3'd5;
    localparam logic [2:0] SCAD_A_MINUS_1         = 3'd6;
    localparam logic [2:0] SCAD_A                 = 3'd7;

    // A operand select codes
    localparam logic [1:0] ASEL_REG  = 2'd0;
    localparam logic [1:0] ASEL_SNUM = 2'd1;
    localparam logic [1:0] ASEL_EXT  = 2'd2;
    localparam logic [1:0] ASEL_ZERO = 2'd3;

    // B operand select codes
    localparam logic [1:0] BSEL_REG  = 2'd0;
    localparam logic [1:0] BSEL_EXT  = 2'd1;
    localparam logic [1:0] BSEL_SNUM = 2'd2;
    localparam logic [1:0] BSEL_ZERO = 2'd3;

    // Counter register indices
    localparam int FE_IDX = 0;
    localparam int SC_IDX = 1;

    // Loop engine states
    typedef enum logic [1:0] {
        LOOP_IDLE = 2'b00,
        LOOP_RUN  = 2'b01,
        LOOP_FIN  = 2'b10
    } loop_state_e;

    // Microsequencer dispatch code derived from the result sign
    function automatic logic [3:0] disp_code(input logic msb);
        return msb ? 4'b0010 : 4'b0000;
    endfunction

endpackage

// File: rtl/scad_alu.sv
// Combinational (W+1)-bit function unit; carry is bit W of the wide result.
module scad_alu
    import scad_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [2:0]   fun,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         carry
);

    localparam logic [W:0] ONE_W1 = {{W{1'b0}}, 1'b1};

    logic [W:0] ax_s;
    logic [W:0] bx_s;
    logic [W:0] wide_s;

    // Zero-extend operands so borrow/carry appears in the top bit
    always_comb begin
        ax_s = {1'b0, a};
        bx_s = {1'b0, b};
    end

    // Function decode; logical functions and pass-through never carry
    always_comb begin
        wide_s = {1'b0, a};
        case (fun)
            SCAD_A_PLUS_A:          wide_s = ax_s + ax_s;
            SCAD_A_OR_B:            wide_s = {1'b0, a | b};
            SCAD_A_MINUS_B_MINUS_1: wide_s = ax_s - bx_s - ONE_W1;
            SCAD_A_MINUS_B:         wide_s = ax_s - bx_s;
            SCAD_A_PLUS_B:          wide_s = ax_s + bx_s;
            SCAD_A_AND_B:           wide_s = {1'b0, a & b};
            SCAD_A_MINUS_1:         wide_s = ax_s - ONE_W1;
            SCAD_A:                 wide_s = {1'b0, a};
            default:                wide_s = {1'b0, a};
        endcase
    end

    assign result = wide_s[W-1:0];
    assign carry  = wide_s[W];

endmodule

// File: rtl/scad_step_engine.sv
// Step-count adder with a small counter register file and an autonomous
// decrement-until-negative loop engine.
module scad_step_engine
    import scad_pkg::*;
#(
    parameter int W    = 10,
    parameter int NREG = 2,
    parameter int IW   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clken,
    input  logic [2:0]      fun,
    input  logic [1:0]      a_sel,
    input  logic [1:0]      b_sel,
    input  logic [IW-1:0]   a_idx,
    input  logic [IW-1:0]   b_idx,
    input  logic [W-1:0]    snum,
    input  logic [W-1:0]    ext_a,
    input  logic [W-1:0]    ext_b,
    input  logic            load,
    input  logic [IW-1:0]   load_idx,
    input  logic            start,
    input  logic [IW-1:0]   loop_idx,
    output logic [W-1:0]    result,
    output logic            carry,
    output logic            zero,
    output logic [3:0]      disp,
    output logic [NREG-1:0] signs,
    output logic            busy,
    output logic            done
);

    localparam logic [W-1:0] ZERO_W = {W{1'b0}};
    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0]  regs_r [NREG];
    loop_state_e   state_r;
    loop_state_e   state_s;
    logic [IW-1:0] l_idx_r;

    logic [W-1:0]  a_reg_s;
    logic [W-1:0]  b_reg_s;
    logic [W-1:0]  st_val_s;
    logic [W-1:0]  lp_val_s;
    logic [W-1:0]  a_op_s;
    logic [W-1:0]  b_op_s;
    logic [W-1:0]  result_s;
    logic          carry_s;
    logic          load_hit_s;

    // Register file read ports; indices with no backing register read as zero
    always_comb begin
        a_reg_s  = ZERO_W;
        b_reg_s  = ZERO_W;
        st_val_s = ZERO_W;
        lp_val_s = ZERO_W;
        for (int i = 0; i < NREG; i++) begin
            a_reg_s  = (a_idx    == IW'(i)) ? regs_r[i] : a_reg_s;
            b_reg_s  = (b_idx    == IW'(i)) ? regs_r[i] : b_reg_s;
            st_val_s = (loop_idx == IW'(i)) ? regs_r[i] : st_val_s;
            lp_val_s = (l_idx_r  == IW'(i)) ? regs_r[i] : lp_val_s;
        end
    end

    // Operand source selection
    always_comb begin
        a_op_s = ZERO_W;
        b_op_s = ZERO_W;
        case (a_sel)
            ASEL_REG:  a_op_s = a_reg_s;
            ASEL_SNUM: a_op_s = snum;
            ASEL_EXT:  a_op_s = ext_a;
            ASEL_ZERO: a_op_s = ZERO_W;
            default:   a_op_s = ZERO_W;
        endcase
        case (b_sel)
            BSEL_REG:  b_op_s = b_reg_s;
            BSEL_EXT:  b_op_s = ext_b;
            BSEL_SNUM: b_op_s = snum;
            BSEL_ZERO: b_op_s = ZERO_W;
            default:   b_op_s = ZERO_W;
        endcase
    end

    scad_alu #(
        .W (W)
    ) u_alu (
        .fun    (fun),
        .a      (a_op_s),
        .b      (b_op_s),
        .result (result_s),
        .carry  (carry_s)
    );

    assign load_hit_s = load && (load_idx == l_idx_r);

    // Loop next-state: a load to the loop register overrides the decrement
    always_comb begin
        state_s = state_r;
        case (state_r)
            LOOP_IDLE: begin
                if (start) begin
                    state_s = st_val_s[W-1] ? LOOP_FIN : LOOP_RUN;
                end else begin
                    state_s = LOOP_IDLE;
                end
            end
            LOOP_RUN: begin
                if (load_hit_s) begin
                    state_s = result_s[W-1] ? LOOP_FIN : LOOP_RUN;
                end else if (lp_val_s == ZERO_W) begin
                    state_s = LOOP_FIN;
                end else begin
                    state_s = LOOP_RUN;
                end
            end
            LOOP_FIN: state_s = LOOP_IDLE;
            default:  state_s = LOOP_IDLE;
        endcase
    end

    // Loop state register, advancing only on enabled edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LOOP_IDLE;
        end else if (clken) begin
            state_r <= state_s;
        end
    end

    // Capture which register the loop is counting when it is started
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_idx_r <= {IW{1'b0}};
        end else if (clken && (state_r == LOOP_IDLE) && start) begin
            l_idx_r <= loop_idx;
        end
    end

    // Counter registers: loop decrement, with an explicit load taking priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= ZERO_W;
            end
        end else if (clken) begin
            for (int i = 0; i < NREG; i++) begin
                if ((state_r == LOOP_RUN) && (l_idx_r == IW'(i))) begin
                    if (load && (load_idx == IW'(i))) begin
                        regs_r[i] <= result_s;
                    end else begin
                        regs_r[i] <= regs_r[i] - ONE_W;
                    end
                end else if (load && (load_idx == IW'(i))) begin
                    regs_r[i] <= result_s;
                end
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_signs
        assign signs[g] = regs_r[g][W-1];
    end

    assign result = result_s;
    assign carry  = carry_s;
    assign zero   = (result_s == ZERO_W);
    assign disp   = disp_code(result_s[W-1]);
    assign busy   = (state_r == LOOP_RUN);
    assign done   = (state_r == LOOP_FIN);

endmodule

// File: tb/tb_scad_step_engine.sv
// Self-checking bench for scad_step_engine: ALU vector table, directed loop
// sequences and randomized traffic against an arithmetic reference model.
module tb_scad_step_engine;

    logic       clk, rst, clken;
    logic [2:0] fun;
    logic [1:0] a_sel, b_sel;
    logic [0:0] a_idx, b_idx, load_idx, loop_idx;
    logic [9:0] snum, ext_a, ext_b;
    logic       load, start;
    logic [9:0] result;
    logic       carry, zero;
    logic [3:0] disp;
    logic [1:0] signs;
    logic       busy, done;

    int n_vec = 0;
    int n_mis = 0;

    // reference model state
    int m_reg [2];
    bit m_run, m_fin;
    int m_l;

    scad_step_engine #(.W(10), .NREG(2), .IW(1)) dut (
        .clk(clk), .rst(rst), .clken(clken), .fun(fun),
        .a_sel(a_sel), .b_sel(b_sel), .a_idx(a_idx), .b_idx(b_idx),
        .snum(snum), .ext_a(ext_a), .ext_b(ext_b),
        .load(load), .load_idx(load_idx), .start(start), .loop_idx(loop_idx),
        .result(result), .carry(carry), .zero(zero), .disp(disp),
        .signs(signs), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0o expected %0o at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_alu(input int f, input int a, input int b,
                                      output int res, output int cy);
        int t;
        case (f)
            0:       t = a + a;
            1:       t = a | b;
            2:       t = a - b - 1;
            3:       t = a - b;
            4:       t = a + b;
            5:       t = a & b;
            6:       t = a - 1;
            default: t = a;
        endcase
        t   = t & 2047;
        res = t & 1023;
        cy  = t >> 10;
    endfunction

    function automatic int op_a();
        case (a_sel)
            2'd0:    return m_reg[a_idx];
            2'd1:    return int'(snum);
            2'd2:    return int'(ext_a);
            default: return 0;
        endcase
    endfunction

    function automatic int op_b();
        case (b_sel)
            2'd0:    return m_reg[b_idx];
            2'd1:    return int'(ext_b);
            2'd2:    return int'(snum);
            default: return 0;
        endcase
    endfunction

    function automatic void model_reset();
        m_reg[0] = 0;
        m_reg[1] = 0;
        m_run = 1'b0;
        m_fin = 1'b0;
        m_l = 0;
    endfunction

    // One enabled clock edge of the reference behaviour
    function automatic void model_edge();
        int res, cy, pre, stv;
        if (clken) begin
            model_alu(int'(fun), op_a(), op_b(), res, cy);
            if (m_fin) begin
                m_fin = 1'b0;
                if (load) m_reg[load_idx] = res;
            end else if (m_run) begin
                if (load && int'(load_idx) == m_l) begin
                    m_reg[m_l] = res;
                    if (res >= 512) begin m_run = 1'b0; m_fin = 1'b1; end
                end else begin
                    pre = m_reg[m_l];
                    m_reg[m_l] = (pre - 1) & 1023;
                    if (pre == 0) begin m_run = 1'b0; m_fin = 1'b1; end
                    if (load) m_reg[load_idx] = res;
                end
            end else begin
                stv = m_reg[loop_idx];
                if (load) m_reg[load_idx] = res;
                if (start) begin
                    if (stv >= 512) m_fin = 1'b1;
                    else begin m_run = 1'b1; m_l = int'(loop_idx); end
                end
            end
        end
    endfunction

    // Check all outputs against the model, then take one clock edge
    task automatic tick();
        int res, cy;
        #1;
        model_alu(int'(fun), op_a(), op_b(), res, cy);
        chk("result", int'(result), res);
        chk("carry", int'(carry), cy);
        chk("zero", int'(zero), (res == 0) ? 1 : 0);
        chk("disp", int'(disp), (res >= 512) ? 2 : 0);
        chk("signs", int'(signs), ((m_reg[1] >= 512) ? 2 : 0) + ((m_reg[0] >= 512) ? 1 : 0));
        chk("busy", int'(busy), int'(m_run));
        chk("done", int'(done), int'(m_fin));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        clken = 1'b1; fun = 3'd7; a_sel = 2'd0; b_sel = 2'd3;
        a_idx = 1'b1; b_idx = 1'b0; snum = 10'o0; ext_a = 10'o0; ext_b = 10'o0;
        load = 1'b0; load_idx = 1'b0; start = 1'b0; loop_idx = 1'b1;
    endtask

    task automatic load_sc(input logic [9:0] v);
        idle_inputs();
        fun = 3'd7; a_sel = 2'd1; snum = v; load = 1'b1; load_idx = 1'b1;
        tick();
        idle_inputs();
    endtask

    typedef struct {
        logic [2:0] fun;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [9:0] snum;
        logic [9:0] exta;
        logic [9:0] extb;
        logic [9:0] exp_res;
        logic       exp_cy;
    } vec_t;

    vec_t tbl [14];
    int   busy_n, done_n;

    initial begin
        tbl[0]  = '{3'd4, 2'd1, 2'd1, 10'o12,   10'o0,   10'o5,   10'o17,   1'b0};
        tbl[1]  = '{3'd3, 2'd1, 2'd1, 10'o3,    10'o0,   10'o5,   10'o1776, 1'b1};
        tbl[2]  = '{3'd2, 2'd1, 2'd1, 10'o5,    10'o0,   10'o5,   10'o1777, 1'b1};
        tbl[3]  = '{3'd0, 2'd1, 2'd1, 10'o777,  10'o0,   10'o0,   10'o1776, 1'b0};
        tbl[4]  = '{3'd0, 2'd1, 2'd1, 10'o1000, 10'o0,   10'o0,   10'o0,    1'b1};
        tbl[5]  = '{3'd1, 2'd1, 2'd1, 10'o1234, 10'o0,   10'o70,  10'o1274, 1'b0};
        tbl[6]  = '{3'd5, 2'd1, 2'd1, 10'o1234, 10'o0,   10'o77,  10'o34,   1'b0};
        tbl[7]  = '{3'd6, 2'd1, 2'd1, 10'o0,    10'o0,   10'o0,   10'o1777, 1'b1};
        tbl[8]  = '{3'd7, 2'd1, 2'd1, 10'o1777, 10'o0,   10'o0,   10'o1777, 1'b0};
        tbl[9]  = '{3'd4, 2'd1, 2'd1, 10'o1777, 10'o0,   10'o1,   10'o0,    1'b1};
        tbl[10] = '{3'd3, 2'd1, 2'd1, 10'o5,    10'o0,   10'o5,   10'o0,    1'b0};
        tbl[11] = '{3'd6, 2'd1, 2'd1, 10'o1,    10'o0,   10'o0,   10'o0,    1'b0};
        tbl[12] = '{3'd4, 2'd3, 2'd3, 10'o777,  10'o777, 10'o777, 10'o0,    1'b0};
        tbl[13] = '{3'd4, 2'd2, 2'd2, 10'o7,    10'o100, 10'o0,   10'o107,  1'b0};

        // Reset state
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_signs", int'(signs), 0);
        chk("rst_sc", int'(result), 0);
        rst = 1'b0;
        @(negedge clk);

        // ALU vector table (fixed expectations)
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            fun = tbl[i].fun; a_sel = tbl[i].asel; b_sel = tbl[i].bsel;
            snum = tbl[i].snum; ext_a = tbl[i].exta; ext_b = tbl[i].extb;
            #1;
            chk("tbl_result", int'(result), int'(tbl[i].exp_res));
            chk("tbl_carry", int'(carry), int'(tbl[i].exp_cy));
            chk("tbl_zero", int'(zero), (tbl[i].exp_res == 10'o0) ? 1 : 0);
            chk("tbl_disp", int'(disp), tbl[i].exp_res[9] ? 2 : 0);
            tick();
        end

        // Load SC from the ALU result
        idle_inputs();
        fun = 3'd4; a_sel = 2'd1; snum = 10'o12; b_sel = 2'd1; ext_b = 10'o5;
        load = 1'b1; load_idx = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("sc_loaded", int'(result), 10'o17);
        chk("sc_sign", int'(signs[1]), 0);

        // Loop from SC=3: four busy cycles then one done pulse
        load_sc(10'o3);
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_n = 0; done_n = 0;
        for (int k = 0; k < 12; k++) begin
            busy_n += int'(busy);
            done_n += int'(done);
            tick();
        end
        chk("loop3_busy_cycles", busy_n, 4);
        chk("loop3_done_pulses", done_n, 1);
        chk("loop3_final_sc", int'(result), 10'o1777);
        chk("loop3_sign", int'(signs[1]), 1);

        // Already negative: no decrement, immediate done; done holds while clken low
        load_sc(10'o1777);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("neg_busy", int'(busy), 0);
        chk("neg_done", int'(done), 1);
        chk("neg_sc", int'(result), 10'o1777);
        clken = 1'b0;
        tick();
        chk("neg_done_hold", int'(done), 1);
        clken = 1'b1;
        tick();
        chk("neg_done_clear", int'(done), 0);

        // Load to the loop register during RUN overrides the decrement
        load_sc(10'o5);
        start = 1'b1;
        tick();
        tick();
        fun = 3'd7; a_sel = 2'd1; snum = 10'o2; load = 1'b1; load_idx = 1'b1;
        tick();
        idle_inputs();
        start = 1'b1;
        #1;
        chk("override_sc", int'(result), 10'o2);
        busy_n = 0; done_n = 0;
        for (int k = 0; k < 10; k++) begin
            busy_n += int'(busy);
            done_n += int'(done);
            tick();
            start = 1'b0;
        end
        chk("override_busy_cycles", busy_n, 3);
        chk("override_done_pulses", done_n, 1);

        // clken 1-0-0-1 during RUN, then reset mid-loop
        load_sc(10'o5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        clken = 1'b0;
        tick();
        tick();
        clken = 1'b1;
        tick();
        chk("clken_sc", int'(result), 10'o3);
        chk("clken_busy", int'(busy), 1);
        rst = 1'b1;
        #2;
        model_reset();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sc", int'(result), 0);
        rst = 1'b0;
        done_n = 0;
        for (int k = 0; k < 6; k++) begin
            done_n += int'(done);
            tick();
        end
        chk("midrst_no_done", done_n, 0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 600; k++) begin
            fun      = 3'($urandom_range(7, 0));
            a_sel    = 2'($urandom_range(3, 0));
            b_sel    = 2'($urandom_range(3, 0));
            a_idx    = 1'($urandom_range(1, 0));
            b_idx    = 1'($urandom_range(1, 0));
            snum     = 10'($urandom_range(15, 0));
            ext_a    = 10'($urandom);
            ext_b    = 10'($urandom);
            load     = ($urandom_range(5, 0) == 0);
            load_idx = 1'($urandom_range(1, 0));
            start    = ($urandom_range(3, 0) == 0);
            loop_idx = 1'($urandom_range(1, 0));
            clken    = ($urandom_range(5, 0) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
